// File: rtl/imem_loader_mp.sv
// Instruction-memory loader: streams program words from the load FIFO into a DEPTH-word array,
// then releases the core and serves NRD independent registered read ports.
module imem_loader_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    RSTcount,
  input  logic                    EMPTY,
  input  logic                    VALIDin,
  input  logic [DATA_W:0]         WRdata,
  input  logic                    RELOAD,
  input  logic [NRD-1:0]          RDen,
  input  logic [NRD*ADDR_W-1:0]   RDaddr,
  output logic [NRD*DATA_W-1:0]   RDdata,
  output logic [NRD-1:0]          VALIDout,
  output logic [NRD-1:0]          RDerr,
  output logic                    POP,
  output logic                    STOP,
  output logic                    PCstart,
  output logic                    LOADED,
  output logic                    OVF,
  output logic [$clog2(DEPTH):0]  WCOUNT
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t                  state_q, state_d;
  logic [AW:0]             wcount_q, wcount_d;
  logic                    stop_q, stop_d;
  logic                    loaded_q, loaded_d;
  logic                    ovf_q, ovf_d;
  logic                    pcstart_q, pcstart_d;
  logic [NRD*DATA_W-1:0]   rddata_p1_q, rddata_p1_d;
  logic [NRD-1:0]          vld_p1_q, vld_p1_d;
  logic [NRD-1:0]          rderr_p1_q, rderr_p1_d;
  logic                    accept;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       mem [DEPTH];

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != '0);
  endfunction

  always_comb begin
    accept   = VALIDin && !EMPTY && (state_q == S_IDLE || state_q == S_LOAD);
    state_d  = state_q;
    wcount_d = wcount_q;
    if (accept) begin
      wcount_d = wcount_q + {{AW{1'b0}}, 1'b1};
      if (WRdata[DATA_W])
        state_d = S_DONE;
      else if (state_q == S_LOAD && wcount_q[AW-1:0] == AW'(DEPTH - 1))
        state_d = S_ERROR;
      else
        state_d = S_LOAD;
    end
    if (RELOAD && (state_q == S_DONE || state_q == S_ERROR)) begin
      state_d  = S_IDLE;
      wcount_d = '0;
    end
    stop_d    = (state_d == S_DONE) || (state_d == S_ERROR);
    loaded_d  = (state_d == S_DONE);
    ovf_d     = (state_d == S_ERROR);
    pcstart_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // Read request stage: data is only served for an image that has fully loaded.
  always_comb begin
    rddata_p1_d = rddata_p1_q;
    vld_p1_d    = '0;
    rderr_p1_d  = '0;
    rd_addr     = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr = RDaddr[k*ADDR_W +: ADDR_W];
      if (RDen[k] && state_q == S_DONE) begin
        vld_p1_d[k] = 1'b1;
        if (addr_bad(rd_addr)) begin
          rderr_p1_d[k]                     = 1'b1;
          rddata_p1_d[k*DATA_W +: DATA_W] = '0;
        end else begin
          rddata_p1_d[k*DATA_W +: DATA_W] = mem[rd_addr[AW+1:2]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTcount) begin
      state_q     <= S_IDLE;
      wcount_q    <= '0;
      stop_q      <= 1'b0;
      loaded_q    <= 1'b0;
      ovf_q       <= 1'b0;
      pcstart_q   <= 1'b0;
      rddata_p1_q <= '0;
      vld_p1_q    <= '0;
      rderr_p1_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcount_q    <= wcount_d;
      stop_q      <= stop_d;
      loaded_q    <= loaded_d;
      ovf_q       <= ovf_d;
      pcstart_q   <= pcstart_d;
      rddata_p1_q <= rddata_p1_d;
      vld_p1_q    <= vld_p1_d;
      rderr_p1_q  <= rderr_p1_d;
    end
  end

  // Array is write-only from the load side; the overflowing word still lands at DEPTH-1.
  always_ff @(posedge clk) begin
    if (accept && RSTcount)
      mem[wcount_q[AW-1:0]] <= WRdata[DATA_W-1:0];
  end

  assign POP      = accept;
  assign STOP     = stop_q;
  assign LOADED   = loaded_q;
  assign OVF      = ovf_q;
  assign PCstart  = pcstart_q;
  assign WCOUNT   = wcount_q;
  assign RDdata   = rddata_p1_q;
  assign VALIDout = vld_p1_q;
  assign RDerr    = rderr_p1_q;
endmodule

// File: tb/tb_imem_loader_mp.sv
// Scoreboard bench for imem_loader_mp: a behavioural model queues expected read results
// at request time and every cycle is compared against control outputs.
module tb_imem_loader_mp;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int NRD    = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic                   clk = 1'b0;
  logic                   rst_n, empty, validin, reload;
  logic [DATA_W:0]        wrdata;
  logic [NRD-1:0]         rden;
  logic [NRD*ADDR_W-1:0]  rdaddr;
  logic [NRD*DATA_W-1:0]  rddata;
  logic [NRD-1:0]         validout, rderr;
  logic                   pop, stop, pcstart, loaded, ovf;
  logic [CW-1:0]          wcount;

  imem_loader_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .RSTcount(rst_n), .EMPTY(empty), .VALIDin(validin), .WRdata(wrdata),
    .RELOAD(reload), .RDen(rden), .RDaddr(rdaddr), .RDdata(rddata), .VALIDout(validout),
    .RDerr(rderr), .POP(pop), .STOP(stop), .PCstart(pcstart), .LOADED(loaded), .OVF(ovf),
    .WCOUNT(wcount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           sbq[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  logic [DATA_W-1:0] mdata [NRD];
  int                ms, mcnt;
  logic              mpc;
  int                vectors, miscompares, pcs, pops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic tick();
    logic              acc;
    logic [ADDR_W-1:0] a;
    rd_exp_t           e;
    int                ns;
    #1;
    acc = validin && !empty && (ms == M_IDLE || ms == M_LOAD);
    check("pop", pop, acc);
    pops += int'(pop);
    for (int k = 0; k < NRD; k++) begin
      a = rdaddr[k*ADDR_W +: ADDR_W];
      e = '0;
      if (!rst_n) begin
        mdata[k] = '0;
      end else if (rden[k] && ms == M_DONE) begin
        e.vld = 1'b1;
        e.err = (a[1:0] != 2'b00) || (a >= ADDR_W'(DEPTH * 4));
        mdata[k] = e.err ? '0 : mdl[a[11:2]];
      end
      e.data = mdata[k];
      sbq.push_back(e);
    end
    ns  = ms;
    mpc = 1'b0;
    if (!rst_n) begin
      ns = M_IDLE; mcnt = 0;
    end else if (acc) begin
      mdl[mcnt] = wrdata[DATA_W-1:0];
      if (wrdata[DATA_W]) ns = M_DONE;
      else if (ms == M_LOAD && mcnt == DEPTH - 1) ns = M_ERR;
      else ns = M_LOAD;
      mcnt++;
    end else if (reload && (ms == M_DONE || ms == M_ERR)) begin
      ns = M_IDLE; mcnt = 0;
    end
    mpc = (ns == M_DONE) && (ms != M_DONE);
    ms  = ns;
    @(posedge clk);
    #1;
    for (int k = 0; k < NRD; k++) begin
      e = sbq.pop_front();
      check($sformatf("validout%0d", k), validout[k], e.vld);
      check($sformatf("rderr%0d", k), rderr[k], e.err);
      check($sformatf("rddata%0d", k), rddata[k*DATA_W +: DATA_W], e.data);
    end
    check("stop", stop, ms == M_DONE || ms == M_ERR);
    check("loaded", loaded, ms == M_DONE);
    check("ovf", ovf, ms == M_ERR);
    check("pcstart", pcstart, mpc);
    check("wcount", wcount, mcnt);
    pcs += int'(pcstart);
  endtask

  task automatic idle(input int n);
    validin = 1'b0; empty = 1'b0; reload = 1'b0; rden = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input logic last);
    validin = 1'b1; empty = 1'b0; wrdata = {last, d};
    tick();
    validin = 1'b0;
  endtask

  task automatic read2(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rden = 2'b11; rdaddr = {a1, a0};
    tick();
    rden = '0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; pcs = 0; pops = 0;
    ms = M_IDLE; mcnt = 0;
    for (int k = 0; k < NRD; k++) mdata[k] = '0;
    rst_n = 1'b0; empty = 1'b1; validin = 1'b0; reload = 1'b0;
    wrdata = '0; rden = '0; rdaddr = '0;
    @(posedge clk); #1;
    tick(); tick();
    rst_n = 1'b1;
    idle(2);

    // Basic 4-word image, with a read issued mid-load.
    push_word(32'h11, 1'b0);
    push_word(32'h22, 1'b0);
    rden = 2'b11; rdaddr = {32'h0, 32'h4};
    push_word(32'h33, 1'b0);
    rden = '0;
    push_word(32'h44, 1'b1);
    idle(3);
    check("pops_first_image", pops, 4);
    check("pcs_first_image", pcs, 1);

    read2(32'h8, 32'h0);
    read2(32'h6, 32'h1000);
    read2(32'hC, 32'hC);
    rden = 2'b01; rdaddr = {32'h4, 32'h0};
    tick();
    idle(2);

    // Re-arm and load a 2-word image over the old one.
    pulse_reload();
    idle(1);
    push_word(32'hAA, 1'b0);
    push_word(32'hBB, 1'b1);
    idle(1);
    read2(32'h0, 32'h8);
    read2(32'h4, 32'hC);
    check("pcs_second_image", pcs, 2);

    // Upstream FIFO stalls for three cycles mid-load.
    pulse_reload();
    push_word(32'h101, 1'b0);
    validin = 1'b1; empty = 1'b1; wrdata = {1'b0, 32'hDEAD};
    tick(); tick(); tick();
    push_word(32'h102, 1'b0);
    push_word(32'h103, 1'b1);
    read2(32'h4, 32'h8);
    check("pcs_stall_image", pcs, 3);

    // Reset during a load aborts it with no release.
    pulse_reload();
    push_word(32'h201, 1'b0);
    push_word(32'h202, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(3);
    read2(32'h0, 32'h4);
    check("pcs_after_abort", pcs, 3);

    // Overflow: DEPTH words with no last flag, then extra words must not be popped.
    pops = 0;
    for (int i = 0; i < DEPTH; i++) push_word(32'hC000_0000 + i, 1'b0);
    for (int i = 0; i < 3; i++) push_word(32'hFFFF_FFFF, 1'b0);
    read2(32'h0, 32'hFFC);
    idle(2);
    check("pops_overflow", pops, DEPTH);
    check("pcs_overflow", pcs, 3);

    // Full image with the last flag on the final slot is legal.
    pulse_reload();
    for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + i, i == DEPTH - 1);
    idle(1);
    read2(32'hFFC, 32'h0);
    read2(32'h1000, 32'h800);
    idle(2);
    check("pcs_full_image", pcs, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
